// File: rtl/sub_64bit_seq_pkg.sv
// Shared definitions for the iterative 64-bit subtractor.
//   - SUB64_CHUNK_LEGAL(c): true when c is a legal chunk width (1..64, power of two)
//   - state_e             : FSM encodings IDLE/RUN/DONE
//   - CC_ZF/CC_SF/CC_OF   : bit positions in the Y86 condition-code register
`ifndef SUB_64BIT_SEQ_PKG_SV
`define SUB_64BIT_SEQ_PKG_SV

`define SUB64_CHUNK_LEGAL(c) (((c) == 1) || ((c) == 2) || ((c) == 4) || ((c) == 8) || \
                              ((c) == 16) || ((c) == 32) || ((c) == 64))

package sub_64bit_seq_pkg;

  localparam int WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Y86 condition-code register layout.
  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam int CC_W  = 3;

endpackage

`endif

// File: rtl/sub_64bit_seq_if.sv
// Request/result bundle of the iterative subtractor.
//   master: drives start, a, b; observes busy, done, diff and flags (requester side)
//   slave : the subtractor itself
interface sub_64bit_seq_if;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] diff;
  logic        overflow;
  logic        zf;
  logic        sf;
  logic        borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, overflow, zf, sf, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, overflow, zf, sf, borrow
  );
endinterface

// File: rtl/sub_64bit_seq_sub_chunk.sv
// Combinational CHUNK-wide subtract slice: sum = x + ~y + cin, cout = carry-out.
// Built as a ripple chain of the 1-bit full_adder cell.
//   x, y : chunk operands (y is inverted internally)
//   cin  : carry into bit 0 (1 for the first chunk of a subtraction)
//   sum  : chunk result, cout : carry out of the top bit

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module sub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a   (x[i]),
      .b   (~y[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];
endmodule

// File: rtl/sub_64bit_seq.sv
// Multi-cycle 64-bit subtractor: diff = a - b, CHUNK bits per clock, LSB chunk first.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any operation in flight)
//   bus : slave side of sub_64bit_seq_if (start/a/b in; busy/done/diff/flags out)
// Results and flags change only on the edge that finishes an operation.
module sub_64bit_seq
  import sub_64bit_seq_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input logic              clk,
  input logic              rst,
  sub_64bit_seq_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!(`SUB64_CHUNK_LEGAL(CHUNK))) begin : g_chunk_check
    $error("sub_64bit_seq: CHUNK must be 1, 2, 4, 8, 16, 32 or 64");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CC_W-1:0]    cc_q, cc_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  int                 lo;
  logic [CHUNK-1:0]   sum_chunk;
  logic               cout_chunk;

  assign lo = int'(idx_q) * CHUNK;

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .x   (op_a_q[lo +: CHUNK]),
    .y   (op_b_q[lo +: CHUNK]),
    .cin (carry_q),
    .sum (sum_chunk),
    .cout(cout_chunk)
  );

  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    work_d   = work_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    cc_d     = cc_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = 1'b1;   // +1 of the two's-complement negation of b
          idx_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[lo +: CHUNK] = sum_chunk;
        carry_d             = cout_chunk;
        idx_d               = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          // Publish from work_d so the final chunk is included on this same edge.
          diff_d        = work_d;
          cc_d[CC_ZF]   = ~|work_d;
          cc_d[CC_SF]   = work_d[WIDTH-1];
          cc_d[CC_OF]   = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) &
                          (work_d[WIDTH-1] != op_a_q[WIDTH-1]);
          borrow_d      = ~cout_chunk;
          idx_d         = '0;
          state_d       = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: working registers are cleared too, so an aborted operation leaves nothing behind.
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      work_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      cc_q     <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      work_q   <= work_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      cc_q     <= cc_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.zf       = cc_q[CC_ZF];
  assign bus.sf       = cc_q[CC_SF];
  assign bus.overflow = cc_q[CC_OF];
  assign bus.borrow   = borrow_q;

endmodule

// File: tb/tb_sub_64bit_seq.sv
// Directed bench for sub_64bit_seq. The main instance uses CHUNK=16; three more
// instances (CHUNK=1, 8, 64) run a shared vector list against a reference a - b.
// Result vectors are packed as {diff, zf, sf, overflow, borrow}.
module tb_sub_64bit_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sub_64bit_seq_if bus16 ();
  sub_64bit_seq_if bus1  ();
  sub_64bit_seq_if bus8  ();
  sub_64bit_seq_if bus64 ();

  sub_64bit_seq #(.CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  sub_64bit_seq #(.CHUNK(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
  sub_64bit_seq #(.CHUNK(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  sub_64bit_seq #(.CHUNK(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

  function automatic logic [67:0] res16();
    return {bus16.diff, bus16.zf, bus16.sf, bus16.overflow, bus16.borrow};
  endfunction

  // Independent reference: 65-bit signed difference for OF, unsigned compare for borrow.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] w;
    logic [63:0] d;
    w = {a[63], a} - {b[63], b};
    d = a - b;
    return {d, (d == 64'd0), d[63], (w[64] != w[63]), (a < b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the CHUNK=16 instance and wait (bounded) for done.
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                       output int lat, output int busy_cyc, output logic [67:0] res);
    bus16.start = 1'b1;
    bus16.a     = av;
    bus16.b     = bv;
    tick();
    bus16.start = 1'b0;
    bus16.a     = ~av;
    bus16.b     = av;
    lat      = 0;
    busy_cyc = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      if (bus16.busy === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
    res = res16();
  endtask

  task automatic test_reset();
    logic [69:0] got;
    rst = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    bus1.start  = 1'b0; bus1.a  = '0; bus1.b  = '0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    bus64.start = 1'b0; bus64.a = '0; bus64.b = '0;
    tick();
    tick();
    got = {bus16.busy, bus16.done, res16()};
    checks++;
    if (got !== 70'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", got, 70'd0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] ta [5];
    logic [63:0] tb [5];
    logic [67:0] te [5];
    int          lat, bcyc;
    logic [67:0] res;
    ta[0] = 64'd10;                  tb[0] = 64'd3;
    te[0] = {64'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    ta[1] = 64'd3;                   tb[1] = 64'd10;
    te[1] = {64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1'b0, 1'b1};
    ta[2] = 64'd5;                   tb[2] = 64'd5;
    te[2] = {64'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    te[3] = {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1};
    ta[4] = 64'h8000_0000_0000_0000; tb[4] = 64'd1;
    te[4] = {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], lat, bcyc, res);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d exp 4", i, lat);
      end
      checks++;
      if (bcyc != 4) begin
        errors++;
        $display("FAIL basic_busy_cycles[%0d] got %0d exp 4", i, bcyc);
      end
      checks++;
      if (res !== te[i]) begin
        errors++;
        $display("FAIL basic_result[%0d] got %h exp %h", i, res, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    logic [67:0] exp_res, res;
    int          dcount, t1;
    exp_res = {64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    dcount  = 0;
    t1      = -1;
    bus16.start = 1'b1;
    bus16.a     = 64'h0001_0000_0000_0000;
    bus16.b     = 64'd1;
    tick();
    bus16.start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 1) begin
        bus16.start = 1'b1;
        bus16.a     = 64'd5;
        bus16.b     = 64'd5;
      end else if (n == 2) begin
        bus16.start = 1'b0;
      end
      tick();
      if (bus16.done === 1'b1) begin
        dcount++;
        if (t1 < 0) begin
          t1  = n;
          res = res16();
        end
      end
    end
    checks++;
    if (dcount != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d exp 1", dcount);
    end
    checks++;
    if (t1 != 4) begin
      errors++;
      $display("FAIL ignore_latency got %0d exp 4", t1);
    end
    checks++;
    if (t1 < 0 || res !== exp_res) begin
      errors++;
      $display("FAIL ignore_result got %h exp %h", res, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] exp1, exp2, r1, r2, hold_val;
    int          dcount, t1, t2;
    exp1   = {64'd999, 1'b0, 1'b0, 1'b0, 1'b0};
    exp2   = {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    dcount = 0;
    t1     = -1;
    t2     = -1;
    r1     = '0;
    r2     = '0;
    bus16.start = 1'b1;
    bus16.a     = 64'd1000;
    bus16.b     = 64'd1;
    tick();
    bus16.a = 64'd7;
    bus16.b = 64'd7;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 5) begin
        bus16.start = 1'b0;
        hold_val    = res16();
      end
      if (bus16.done === 1'b1) begin
        dcount++;
        if (dcount == 1) begin
          t1 = n;
          r1 = res16();
          bus16.a = 64'd0;
          bus16.b = 64'd1;
        end else if (dcount == 2) begin
          t2 = n;
          r2 = res16();
        end
      end
    end
    bus16.start = 1'b0;
    checks++;
    if (dcount != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d exp 2", dcount);
    end
    checks++;
    if (t1 != 4) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d exp 4", t1);
    end
    checks++;
    if (t2 - t1 != 5) begin
      errors++;
      $display("FAIL b2b_spacing got %0d exp 5", t2 - t1);
    end
    checks++;
    if (r1 !== exp1) begin
      errors++;
      $display("FAIL b2b_first_result got %h exp %h", r1, exp1);
    end
    checks++;
    if (hold_val !== exp1) begin
      errors++;
      $display("FAIL b2b_hold_during_run got %h exp %h", hold_val, exp1);
    end
    checks++;
    if (r2 !== exp2) begin
      errors++;
      $display("FAIL b2b_second_result got %h exp %h", r2, exp2);
    end
  endtask

  task automatic test_reset_abort();
    logic [69:0] got;
    int          dcount, lat, bcyc;
    logic [67:0] res, exp_res;
    exp_res = {64'd99, 1'b0, 1'b0, 1'b0, 1'b0};
    bus16.start = 1'b1;
    bus16.a     = 64'd123;
    bus16.b     = 64'd5;
    tick();
    bus16.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    got = {bus16.busy, bus16.done, res16()};
    checks++;
    if (got !== 70'd0) begin
      errors++;
      $display("FAIL abort_state got %h exp %h", got, 70'd0);
    end
    rst    = 1'b0;
    dcount = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (bus16.done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d exp 0", dcount);
    end
    do_op(64'd100, 64'd1, lat, bcyc, res);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL abort_next_latency got %0d exp 4", lat);
    end
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL abort_next_result got %h exp %h", res, exp_res);
    end
    tick();
  endtask

  task automatic test_chunk_variants();
    logic [63:0] va [8];
    logic [63:0] vb [8];
    int          lat [4];
    int          nexp [4];
    logic [67:0] res [4];
    logic [67:0] exp_res;
    int          n;
    va[0] = 64'd10;                  vb[0] = 64'd3;
    va[1] = 64'd3;                   vb[1] = 64'd10;
    va[2] = 64'd5;                   vb[2] = 64'd5;
    va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1;
    va[5] = 64'h0001_0000_0000_0000; vb[5] = 64'd1;
    va[6] = 64'd100;                 vb[6] = 64'd1;
    va[7] = 64'h1234_5678_9ABC_DEF0; vb[7] = 64'hFEDC_BA98_7654_3210;
    nexp[0] = 4; nexp[1] = 64; nexp[2] = 8; nexp[3] = 1;
    for (int i = 0; i < 8; i++) begin
      bus16.start = 1'b1; bus16.a = va[i]; bus16.b = vb[i];
      bus1.start  = 1'b1; bus1.a  = va[i]; bus1.b  = vb[i];
      bus8.start  = 1'b1; bus8.a  = va[i]; bus8.b  = vb[i];
      bus64.start = 1'b1; bus64.a = va[i]; bus64.b = vb[i];
      tick();
      bus16.start = 1'b0;
      bus1.start  = 1'b0;
      bus8.start  = 1'b0;
      bus64.start = 1'b0;
      for (int k = 0; k < 4; k++) lat[k] = -1;
      n = 0;
      while (n < 80 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0)) begin
        tick();
        n++;
        if (bus16.done === 1'b1 && lat[0] < 0) begin
          lat[0] = n;
          res[0] = res16();
        end
        if (bus1.done === 1'b1 && lat[1] < 0) begin
          lat[1] = n;
          res[1] = {bus1.diff, bus1.zf, bus1.sf, bus1.overflow, bus1.borrow};
        end
        if (bus8.done === 1'b1 && lat[2] < 0) begin
          lat[2] = n;
          res[2] = {bus8.diff, bus8.zf, bus8.sf, bus8.overflow, bus8.borrow};
        end
        if (bus64.done === 1'b1 && lat[3] < 0) begin
          lat[3] = n;
          res[3] = {bus64.diff, bus64.zf, bus64.sf, bus64.overflow, bus64.borrow};
        end
      end
      exp_res = model(va[i], vb[i]);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (lat[k] != nexp[k]) begin
          errors++;
          $display("FAIL chunk%0d_latency[%0d] got %0d exp %0d", 64 / nexp[k], i, lat[k], nexp[k]);
        end
        checks++;
        if (lat[k] < 0 || res[k] !== exp_res) begin
          errors++;
          $display("FAIL chunk%0d_result[%0d] got %h exp %h", 64 / nexp[k], i, res[k], exp_res);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_chunk_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sub_64bit_seq.md
Name: sub_64bit_seq

Overview:
Multi-cycle 64-bit two's-complement subtractor computing diff = a - b, CHUNK bits per clock, least-significant chunk first. It is the inverse-direction companion of the 64-bit adder in the AL unit and serves the Y86 subq path (valB - valA) when a short-critical-path, iterative implementation is preferred. It also produces the condition codes ZF, SF and OF, plus an unsigned borrow flag.

Parameters:
CHUNK, 16, bits processed per cycle; legal values are 1, 2, 4, 8, 16, 32 and 64; elaboration error otherwise.
NCHUNK, 64/CHUNK, derived (localparam): number of compute cycles.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request; accepted only when busy=0.
a  input  64  minuend, signed; sampled on the accepting edge only.
b  input  64  subtrahend, signed; sampled on the accepting edge only.
busy  output  1  high while computing.
done  output  1  one-cycle pulse; result and flags valid from this cycle on.
diff  output  64  a - b, modulo 2^64.
overflow  output  1  signed overflow (OF).
zf  output  1  diff == 0.
sf  output  1  diff[63].
borrow  output  1  unsigned a < b, i.e. inverted carry-out of a + ~b + 1.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state IDLE; busy, done, diff, overflow, zf, sf and borrow are all 0; the working registers are cleared. Reset asserted mid-operation aborts immediately: no done pulse, previous results are lost.
- States:
  - IDLE: start=1 latches a and b into op registers, sets carry=1, idx=0, clears the work register, moves to RUN. start=0 stays in IDLE.
  - RUN: on each edge, computes chunk idx of op_a + ~op_b + carry, writes it into the work register, and updates carry and idx.
    - When idx == NCHUNK-1, loads diff from the completed work register and computes the flags on the same edge, then moves to DONE.
  - DONE: done=1 for exactly one cycle; moves to IDLE. A start during DONE is accepted, behaves as in IDLE, and moves to RUN (back-to-back operation).
- busy = 1 in RUN only.
- start while busy is ignored; op registers and results are untouched.
- Latency: if start is accepted on edge E0, chunks are computed on edges E1..E(NCHUNK), and done is high in the cycle after edge E(NCHUNK). For CHUNK=16, done rises 4 cycles after the accepting edge. For CHUNK=64 it rises after 1 cycle.
- Holding: diff and the flags hold their values until the next op finishes or rst. They never show partial results while RUN is in progress.
- Arithmetic:
  - The inter-chunk carry is registered and the initial carry-in is 1.
  - borrow = ~carry_out of the MSB chunk.
  - overflow = (op_a[63] != op_b[63]) & (diff[63] != op_a[63]).
  - zf = ~|diff.
  - sf = diff[63].
- a and b may change freely after the accepting edge.

Decomposition:
- Shared package/header: CHUNK legality check macro; state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; CC bit indices for the Y86 condition-code register (ZF=0, SF=1, OF=2).
- Sub-module sub_chunk: combinational CHUNK-wide adder over (x, ~y, cin), returning sum and cout. It is built from the existing 1-bit full-adder cell in a generate loop. Instantiate once, with the chunk selected by idx via indexed part-select.

Test Plan:
- CHUNK=16, a=10, b=3 -> diff=7, zf=0, sf=0, overflow=0, borrow=0; done exactly 4 cycles after the accepting edge; busy high for 4 cycles.
- a=3, b=10 -> diff=0xFFFFFFFFFFFFFFF9, sf=1, borrow=1, overflow=0. Then a=5, b=5 -> diff=0, zf=1, borrow=0.
- a=0x7FFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF -> diff=0x8000000000000000, overflow=1, sf=1, borrow=1. Then a=0x8000000000000000, b=1 -> diff=0x7FFFFFFFFFFFFFFF, overflow=1, sf=0, borrow=0.
- Cross-chunk borrow: a=0x0001000000000000, b=1 -> diff=0x0000FFFFFFFFFFFF. Also pulse start with different operands during RUN -> ignored; result unchanged; exactly one done pulse.
- Back-to-back: start held high through the DONE cycle with new operands -> second result correct; done pulses spaced 5 cycles apart for CHUNK=16.
- rst asserted on the 2nd RUN cycle -> next cycle: busy=0, diff=0, all flags 0, no done. A following op (a=100, b=1) gives diff=99. Repeat the whole plan with CHUNK=1, 8 and 64 against a reference model of a - b.
